alu_wide_seq: RTL and testbench

//  Multi-cycle, slice-serial wide ALU: successor to the 128-bit ripple ALU, generalised in width and slice size.

---
 rtl/alu_wide_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_wide_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_seq.sv
// Slice-serial wide ALU. Each transaction is processed SLICE bits per clock.
// The carry between slices is held in a register. Flags are set on the last slice.
module alu_wide_seq #(
    parameter int DWIDTH = 128,
    parameter int SLICE  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] op1,
    input  logic [DWIDTH-1:0] op2,
    input  logic [2:0]        opsel,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] result,
    output logic              c_flag,
    output logic              z_flag,
    output logic              o_flag,
    output logic              s_flag
);
    localparam int NSLICE = DWIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0]  LAST       = CNT_W'(NSLICE - 1);
    localparam logic [DWIDTH-1:0] SLICE_MASK = DWIDTH'({SLICE{1'b1}});

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (DWIDTH % SLICE != 0) begin : g_bad_slice
        $error("alu_wide_seq: DWIDTH must be a multiple of SLICE");
    end

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              carry;
    logic              z_run;
    logic [DWIDTH-1:0] a_q;
    logic [DWIDTH-1:0] b_q;
    logic [2:0]        sel_q;
    logic              mode_q;

    logic [DWIDTH-1:0] a_eff;
    logic [DWIDTH-1:0] b_eff;
    logic              cin_eff;
    logic [31:0]       sh;
    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  b_sl;
    logic [SLICE:0]    sl_out;
    logic [SLICE-1:0]  sl_val;
    logic              sl_cout;
    logic              sl_zero;
    logic              sl_ovf;

    // One slice of the operation: {carry out, value}. Logic ops never carry.
    function automatic logic [SLICE:0] slice_op(input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b,
                                                input logic             cin,
                                                input logic [2:0]       sel,
                                                input logic             lg);
        logic [SLICE-1:0] v;
        if (!lg) begin
            slice_op = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
        end else begin
            case (sel)
                3'b000:  v = a & b;
                3'b001:  v = a | b;
                3'b010:  v = a ^ b;
                3'b011:  v = ~a;
                3'b100:  v = ~(a | b);
                3'b101:  v = ~(a & b);
                3'b110:  v = ~(a ^ b);
                default: v = b;
            endcase
            slice_op = {1'b0, v};
        end
    endfunction

    // Every arithmetic op is rewritten as A + B + cin before it is captured.
    always_comb begin
        a_eff   = op1;
        b_eff   = op2;
        cin_eff = 1'b0;
        if (!mode) begin
            case (opsel)
                3'b000: ;
                3'b001: begin b_eff = ~op2; cin_eff = 1'b1; end
                3'b010: begin b_eff = '0;   cin_eff = 1'b1; end
                3'b011: b_eff = '1;
                3'b100: begin a_eff = '0; b_eff = ~op2; cin_eff = 1'b1; end
                default: b_eff = '0;
            endcase
        end
    end

    // Select the current slice and evaluate it. Overflow uses the operand and result sign bits.
    assign sh      = 32'(cnt) * 32'(SLICE);
    assign a_sl    = SLICE'(a_q >> sh);
    assign b_sl    = SLICE'(b_q >> sh);
    assign sl_out  = slice_op(a_sl, b_sl, carry, sel_q, mode_q);
    assign sl_val  = sl_out[SLICE-1:0];
    assign sl_cout = sl_out[SLICE];
    assign sl_zero = (sl_val == '0);
    assign sl_ovf  = (a_sl[SLICE-1] == b_sl[SLICE-1]) && (sl_val[SLICE-1] != a_sl[SLICE-1]);

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Capture in IDLE, one slice per cycle in BUSY, then hold in DONE until the result is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            z_run  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sel_q  <= '0;
            mode_q <= 1'b0;
            result <= '0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
            o_flag <= 1'b0;
            s_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q    <= a_eff;
                        b_q    <= b_eff;
                        carry  <= cin_eff;
                        sel_q  <= opsel;
                        mode_q <= mode;
                        cnt    <= '0;
                        z_run  <= 1'b1;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    result <= (result & ~(SLICE_MASK << sh)) | (DWIDTH'(sl_val) << sh);
                    carry  <= sl_cout;
                    z_run  <= z_run & sl_zero;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        c_flag <= ~mode_q & sl_cout;
                        o_flag <= ~mode_q & sl_ovf;
                        s_flag <= sl_val[SLICE-1];
                        z_flag <= z_run & sl_zero;
                        cnt    <= '0;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq. Three instances (SLICE = 32, 128, 8) are fed the same transactions.
module tb_alu_wide_seq;
    localparam int W = 128;
    localparam logic [W-1:0] ALL1 = {W{1'b1}};
    localparam logic [W-1:0] MSB1 = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic [2:0]   opsel = '0;
    logic         mode = 1'b0;

    logic [2:0]        in_rdy;
    logic [2:0]        out_vld;
    logic [2:0][W-1:0] res;
    logic [2:0]        cf;
    logic [2:0]        zf;
    logic [2:0]        of;
    logic [2:0]        sf;

    int ns[3] = '{4, 1, 16};
    int sl[3] = '{32, 128, 8};
    int errors = 0;
    int checks = 0;

    alu_wide_seq #(.DWIDTH(W), .SLICE(32)) u_s32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]),
        .op1(op1), .op2(op2), .opsel(opsel), .mode(mode),
        .out_valid(out_vld[0]), .out_ready(out_ready), .result(res[0]),
        .c_flag(cf[0]), .z_flag(zf[0]), .o_flag(of[0]), .s_flag(sf[0]));

    alu_wide_seq #(.DWIDTH(W), .SLICE(128)) u_s128 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]),
        .op1(op1), .op2(op2), .opsel(opsel), .mode(mode),
        .out_valid(out_vld[1]), .out_ready(out_ready), .result(res[1]),
        .c_flag(cf[1]), .z_flag(zf[1]), .o_flag(of[1]), .s_flag(sf[1]));

    alu_wide_seq #(.DWIDTH(W), .SLICE(8)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]),
        .op1(op1), .op2(op2), .opsel(opsel), .mode(mode),
        .out_valid(out_vld[2]), .out_ready(out_ready), .result(res[2]),
        .c_flag(cf[2]), .z_flag(zf[2]), .o_flag(of[2]), .s_flag(sf[2]));

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: true signed/unsigned arithmetic on wide integers.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] sel, input logic md,
                                  output logic [W-1:0] r, output logic c, output logic o);
        logic signed [W+1:0] sa;
        logic signed [W+1:0] sb;
        logic signed [W+1:0] t;
        logic [W:0]          u;
        sa = $signed({{2{a[W-1]}}, a});
        sb = $signed({{2{b[W-1]}}, b});
        t = sa;
        c = 1'b0;
        o = 1'b0;
        r = '0;
        if (md) begin
            case (sel)
                3'd0: r = a & b;
                3'd1: r = a | b;
                3'd2: r = a ^ b;
                3'd3: r = ~a;
                3'd4: r = ~(a | b);
                3'd5: r = ~(a & b);
                3'd6: r = ~(a ^ b);
                default: r = b;
            endcase
        end else begin
            case (sel)
                3'd0: begin t = sa + sb; u = {1'b0, a} + {1'b0, b}; c = u[W]; end
                3'd1: begin t = sa - sb; c = (a >= b); end
                3'd2: begin t = sa + 1;  c = (a == ALL1); end
                3'd3: begin t = sa - 1;  c = (a != '0); end
                3'd4: begin t = -sb;     c = (b == '0); end
                default: begin t = sa;   c = 1'b0; end
            endcase
            r = t[W-1:0];
            o = (t[W+1:W-1] != {3{t[W-1]}});
        end
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = ALL1;
            2: v = MSB1;
            3: v = MAXP;
            default: v = {$urandom, $urandom, $urandom, $urandom};
        endcase
        return v;
    endfunction

    // Issue one transaction to all instances and check latency, result and flags of each.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] sel, input logic md, input logic [W-1:0] er,
                          input logic ec, input logic ez, input logic eo, input logic es);
        int           lat[3];
        logic [W-1:0] r[3];
        logic [3:0]   fl[3];
        logic [2:0]   seen;
        lat = '{0, 0, 0};
        r = '{'0, '0, '0};
        fl = '{4'h0, 4'h0, 4'h0};
        seen = '0;
        @(posedge clk); #1;
        op1 = a; op2 = b; opsel = sel; mode = md; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op1 = {$urandom, $urandom, $urandom, $urandom};
        op2 = {$urandom, $urandom, $urandom, $urandom};
        opsel = 3'($urandom); mode = 1'($urandom);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                if (!seen[k] && out_vld[k]) begin
                    seen[k] = 1'b1;
                    lat[k] = cyc;
                    r[k] = res[k];
                    fl[k] = {cf[k], zf[k], of[k], sf[k]};
                end
            end
            if (seen == 3'b111) break;
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s/s%0d latency", name, sl[k]), W'(lat[k]), W'(ns[k]));
            chk($sformatf("%s/s%0d result", name, sl[k]), r[k], er);
            chk($sformatf("%s/s%0d flags czos", name, sl[k]), W'(fl[k]), W'({ec, ez, eo, es}));
        end
    endtask

    task automatic run_rand(input int idx);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   sel;
        logic         md;
        logic [W-1:0] r;
        logic         c;
        logic         o;
        a = rnd_op();
        b = rnd_op();
        sel = 3'($urandom_range(0, 7));
        md = 1'($urandom_range(0, 1));
        model(a, b, sel, md, r, c, o);
        run_op($sformatf("rand%0d m%0d s%0d", idx, md, sel), a, b, sel, md, r, c, (r == '0), o, r[W-1]);
    endtask

    initial begin
        logic [W-1:0] lop1;
        logic [W-1:0] lop2;
        lop1 = {16{8'hF0}};
        lop2 = {8'hFF, {(W-8){1'b0}}};

        // Reset for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset/s%0d in_ready", sl[k]), W'(in_rdy[k]), W'(1));
            chk($sformatf("reset/s%0d out_valid", sl[k]), W'(out_vld[k]), W'(0));
            chk($sformatf("reset/s%0d result", sl[k]), res[k], '0);
            chk($sformatf("reset/s%0d flags", sl[k]), W'({cf[k], zf[k], of[k], sf[k]}), W'(0));
        end

        // Handshake with the consumer stalling
        @(posedge clk); #1;
        op1 = W'(1); op2 = W'(2); opsel = 3'd0; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("hs in_ready busy", W'(in_rdy[0]), W'(0));
        repeat (3) @(posedge clk);
        #1 chk("hs early valid", W'(out_vld[0]), W'(0));
        @(posedge clk); #1;
        chk("hs valid at T+4", W'(out_vld[0]), W'(1));
        chk("hs result", res[0], W'(3));
        chk("hs flags", W'({cf[0], zf[0], of[0], sf[0]}), W'(0));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("hs hold%0d result", i), res[0], W'(3));
            chk($sformatf("hs hold%0d in_ready", i), W'(in_rdy[0]), W'(0));
            chk($sformatf("hs hold%0d out_valid", i), W'(out_vld[0]), W'(1));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs release in_ready", W'(in_rdy[0]), W'(1));
        chk("hs release out_valid", W'(out_vld[0]), W'(0));
        repeat (16) @(posedge clk);

        // Directed arithmetic
        run_op("add 1+2", W'(1), W'(2), 3'd0, 1'b0, W'(3), 0, 0, 0, 0);
        run_op("add slice carry", W'(32'hFFFF_FFFF), W'(1), 3'd0, 1'b0, W'(64'h1_0000_0000), 0, 0, 0, 0);
        run_op("add wrap", ALL1, W'(1), 3'd0, 1'b0, '0, 1, 1, 0, 0);
        run_op("add ovf", MAXP, W'(1), 3'd0, 1'b0, MSB1, 0, 0, 1, 1);
        run_op("sub 5-7", W'(5), W'(7), 3'd1, 1'b0, ~W'(1), 0, 0, 0, 1);
        run_op("sub ovf", MSB1, W'(1), 3'd1, 1'b0, MAXP, 1, 0, 1, 0);
        run_op("inc ones", ALL1, W'(9), 3'd2, 1'b0, '0, 1, 1, 0, 0);
        run_op("dec 0", '0, W'(9), 3'd3, 1'b0, ALL1, 0, 0, 0, 1);
        run_op("neg 1", W'(123), W'(1), 3'd4, 1'b0, ALL1, 0, 0, 0, 1);
        run_op("neg 0", W'(123), '0, 3'd4, 1'b0, '0, 1, 1, 0, 0);
        run_op("pass arith", MSB1, ALL1, 3'd6, 1'b0, MSB1, 0, 0, 0, 1);

        // Directed logic
        run_op("and", lop1, lop2, 3'd0, 1'b1, {8'hF0, {(W-8){1'b0}}}, 0, 0, 0, 1);
        run_op("xor", lop1, lop2, 3'd2, 1'b1, {8'h0F, {15{8'hF0}}}, 0, 0, 0, 0);
        run_op("not", lop1, lop2, 3'd3, 1'b1, {16{8'h0F}}, 0, 0, 0, 0);
        run_op("pass op2", lop1, lop2, 3'd7, 1'b1, lop2, 0, 0, 0, 1);

        // Abort by reset while busy
        @(posedge clk); #1;
        op1 = ALL1; op2 = ALL1; opsel = 3'd0; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort s32 no valid", W'(out_vld[0]), W'(0));
        chk("abort s8 no valid", W'(out_vld[2]), W'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("abort/s%0d in_ready", sl[k]), W'(in_rdy[k]), W'(1));
            chk($sformatf("abort/s%0d out_valid", sl[k]), W'(out_vld[k]), W'(0));
            chk($sformatf("abort/s%0d result", sl[k]), res[k], '0);
            chk($sformatf("abort/s%0d flags", sl[k]), W'({cf[k], zf[k], of[k], sf[k]}), W'(0));
        end
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            chk($sformatf("abort quiet%0d", i), W'(out_vld), W'(0));
        end
        run_op("add after abort", W'(40), W'(2), 3'd0, 1'b0, W'(42), 0, 0, 0, 0);

        // Random transactions against the reference model
        for (int i = 0; i < 1500; i++) run_rand(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
